wt_inval_queue: RTL and testbench



---
 rtl/wt_cache_pkg.sv | 7 +
 rtl/wt_inval_queue.sv | 121 ++++++++++++
 tb/tb_wt_inval_queue.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/wt_cache_pkg.sv
// rtl/wt_cache_pkg.sv - write-through cache subsystem constants shared with the invalidation queue
package wt_cache_pkg;

    localparam int unsigned DCACHE_LINE_WIDTH = 128;
    localparam int unsigned INVAL_Q_DEPTH     = 4;

endpackage

// File: rtl/wt_inval_queue.sv
// rtl/wt_inval_queue.sv - coalescing FIFO of line-aligned snoop invalidations
// feeding the write-through cache invalidation port.
module wt_inval_queue
    import wt_cache_pkg::*;
#(
    parameter int unsigned Depth     = INVAL_Q_DEPTH,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned LineBytes = DCACHE_LINE_WIDTH / 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       snoop_valid_i,
    output logic                       snoop_ready_o,
    input  logic [AddrWidth-1:0]       snoop_addr_i,
    output logic                       inval_valid_o,
    input  logic                       inval_ready_i,
    output logic [AddrWidth-1:0]       inval_addr_o,
    input  logic                       flush_i,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(Depth+1)-1:0] usage_o,
    output logic [15:0]                dup_cnt_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [AddrWidth-1:0] LineMask = ~(AddrWidth'(LineBytes - 1));

    logic [AddrWidth-1:0] addr_q [Depth];
    logic [AddrWidth-1:0] addr_d [Depth];
    logic [Depth-1:0]     valid_q, valid_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [15:0]          dup_q, dup_d;

    logic [AddrWidth-1:0] line_addr;
    logic                 pop, accept, push, coalesce;
    logic                 match_any, match_live;

    assign line_addr     = snoop_addr_i & LineMask;
    assign inval_valid_o = valid_q[rd_ptr_q];
    assign inval_addr_o  = addr_q[rd_ptr_q];
    assign empty_o       = (cnt_q == '0);
    assign full_o        = (cnt_q == CntW'(Depth));
    assign usage_o       = cnt_q;
    assign dup_cnt_o     = dup_q;

    assign pop = inval_valid_o && inval_ready_i && !flush_i;

    // match_any gates readiness so it stays independent of inval_ready_i;
    // match_live excludes the head leaving this cycle, which must be re-enqueued.
    always_comb begin
        match_any  = 1'b0;
        match_live = 1'b0;
        for (int i = 0; i < int'(Depth); i++) begin
            if (valid_q[i] && (addr_q[i] == line_addr)) begin
                match_any = 1'b1;
                if (!(pop && (rd_ptr_q == PtrW'(i)))) begin
                    match_live = 1'b1;
                end
            end
        end
    end

    assign snoop_ready_o = !flush_i && (!full_o || match_any);
    assign accept        = snoop_valid_i && snoop_ready_o;
    assign push          = accept && !match_live;
    assign coalesce      = accept && match_live;

    always_comb begin
        addr_d   = addr_q;
        valid_d  = valid_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        dup_d    = dup_q;
        if (flush_i) begin
            valid_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // Pop is applied before push: a full queue re-enqueuing its own head reuses that slot.
            if (pop) begin
                valid_d[rd_ptr_q] = 1'b0;
                rd_ptr_d          = rd_ptr_q + PtrW'(1);
            end
            if (push) begin
                valid_d[wr_ptr_q] = 1'b1;
                addr_d[wr_ptr_q]  = line_addr;
                wr_ptr_d          = wr_ptr_q + PtrW'(1);
            end
            cnt_d = cnt_q + CntW'(push) - CntW'(pop);
            if (coalesce && (dup_q != 16'hFFFF)) begin
                dup_d = dup_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                addr_q[i] <= '0;
            end
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            dup_q    <= '0;
        end else begin
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            dup_q    <= dup_d;
        end
    end

endmodule

// File: tb/tb_wt_inval_queue.sv
// tb/tb_wt_inval_queue.sv - randomized and directed checks of wt_inval_queue
// against a queue-based reference model.
module tb_wt_inval_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        snoop_valid;
    logic        snoop_ready;
    logic [63:0] snoop_addr;
    logic        inval_valid;
    logic        inval_ready;
    logic [63:0] inval_addr;
    logic        flush;
    logic        empty;
    logic        full;
    logic [2:0]  usage;
    logic [15:0] dup_cnt;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [63:0] mq [$];
    int unsigned mdup = 0;

    always #5 clk = ~clk;

    wt_inval_queue dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .snoop_valid_i (snoop_valid),
        .snoop_ready_o (snoop_ready),
        .snoop_addr_i  (snoop_addr),
        .inval_valid_o (inval_valid),
        .inval_ready_i (inval_ready),
        .inval_addr_o  (inval_addr),
        .flush_i       (flush),
        .empty_o       (empty),
        .full_o        (full),
        .usage_o       (usage),
        .dup_cnt_o     (dup_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        check("inval_valid", 64'(inval_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) check("inval_addr", inval_addr, mq[0]);
        check("usage", 64'(usage), 64'(mq.size()));
        check("empty", 64'(empty), 64'(mq.size() == 0));
        check("full", 64'(full), 64'(mq.size() == DEPTH));
        check("dup_cnt", 64'(dup_cnt), 64'(mdup));
    endtask

    // One clock cycle: drive inputs mid-cycle, compare, then advance the model past the edge.
    task automatic step(input logic v, input logic [63:0] ad, input logic rdy, input logic fl);
        logic [63:0] a;
        bit          do_pop, any, live, exp_rdy;
        @(negedge clk);
        snoop_valid = v;
        snoop_addr  = ad;
        inval_ready = rdy;
        flush       = fl;
        #1;
        check_state();
        a      = ad & ~64'hF;
        do_pop = !fl && (mq.size() != 0) && rdy;
        any    = 1'b0;
        live   = 1'b0;
        foreach (mq[i]) begin
            if (mq[i] == a) begin
                any = 1'b1;
                if (!(do_pop && i == 0)) live = 1'b1;
            end
        end
        exp_rdy = !fl && ((mq.size() < DEPTH) || any);
        check("snoop_ready", 64'(snoop_ready), 64'(exp_rdy));
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (v && exp_rdy) begin
                if (live) begin
                    if (mdup < 32'hFFFF) mdup++;
                end else begin
                    mq.push_back(a);
                end
            end
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 64'h0, rdy, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_dup;
        rst_n       = 1'b0;
        snoop_valid = 1'b0;
        snoop_addr  = '0;
        inval_ready = 1'b0;
        flush       = 1'b0;
        #12;
        check_state();
        check("rst_inval_addr", inval_addr, 64'h0);
        check("rst_snoop_ready", 64'(snoop_ready), 64'h1);
        rst_n = 1'b1;

        // single unaligned snoop
        step(1'b1, 64'h8000_0123, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // coalesce
        step(1'b1, 64'h1000, 1'b0, 1'b0);
        step(1'b1, 64'h1008, 1'b0, 1'b0);
        step(1'b1, 64'h2000, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // full backpressure, coalesce into full queue, full with pop still rejects new line
        for (int i = 0; i < DEPTH; i++) step(1'b1, 64'h9000 + 64'(i) * 64'h10, 1'b0, 1'b0);
        step(1'b1, 64'hA000, 1'b0, 1'b0);
        step(1'b1, 64'h9025, 1'b0, 1'b0);
        step(1'b1, 64'hA000, 1'b1, 1'b0);
        step(1'b1, 64'hA000, 1'b0, 1'b0);
        step(1'b1, 64'h9010, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

        // head race
        step(1'b1, 64'h3000, 1'b0, 1'b0);
        step(1'b1, 64'h3004, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // flush with pop and snoop offered
        step(1'b1, 64'h6000, 1'b0, 1'b0);
        step(1'b1, 64'h6010, 1'b0, 1'b0);
        step(1'b1, 64'h6020, 1'b0, 1'b0);
        step(1'b1, 64'h7000, 1'b1, 1'b1);
        idle(1'b0);

        // asynchronous reset mid-cycle
        step(1'b1, 64'hB000, 1'b0, 1'b0);
        step(1'b1, 64'hB010, 1'b0, 1'b0);
        @(negedge clk);
        snoop_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        mdup = 0;
        check_state();
        check("arst_inval_addr", inval_addr, 64'h0);
        #1;
        rst_n = 1'b1;

        // random traffic over 64 lines
        for (int n = 0; n < 1000; n++) begin
            logic [63:0] ad;
            ad = 64'h4000_0000 + 64'($urandom_range(0, 63)) * 64'h10 + 64'($urandom_range(0, 15));
            step(($urandom_range(0, 3) != 0), ad, ($urandom_range(0, 1) != 0),
                 ($urandom_range(0, 63) == 0));
        end

        // drive the duplicate counter into saturation
        step(1'b0, 64'h0, 1'b0, 1'b1);
        step(1'b1, 64'h5000, 1'b0, 1'b0);
        n_dup = 65535 - int'(mdup) - 2;
        for (int n = 0; n < n_dup; n++) step(1'b1, 64'h5008, 1'b0, 1'b0);
        for (int n = 0; n < 6; n++) step(1'b1, 64'h500F, 1'b0, 1'b0);
        idle(1'b0);
        check("dup_saturated", 64'(dup_cnt), 64'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
